instruction_dispatcher: RTL and testbench



---
 rtl/dispatch_pkg.sv | 26 ++
 rtl/instruction_dispatcher_if.sv | 48 ++++
 rtl/dispatch_decode.sv | 58 +++++
 rtl/instruction_dispatcher.sv | 153 +++++++++++++++
 tb/tb_instruction_dispatcher.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared definitions for the dual-issue instruction dispatcher.
//   - RV32 major opcode constants used by the field decoder
//   - dec_fields_t: register fields and usage flags extracted from one instruction
package dispatch_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [4:0] rd;        // 0 when the instruction writes no register
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       is_ctrl;   // branch / jump / system: ends a dispatch pair
    } dec_fields_t;

endpackage

// File: rtl/instruction_dispatcher_if.sv
// instruction_dispatcher_if: bundles the buffer-side, issue-side and writeback
// signals of the dispatcher.
//   master : the dispatcher (drives pops and issue slots)
//   slave  : the surrounding pipeline (buffer entries, readies, writebacks, flush)
interface instruction_dispatcher_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic [XLEN-1:0] entry0_instruction;
    logic [XLEN-1:0] entry0_address;
    logic [XLEN-1:0] entry1_instruction;
    logic [XLEN-1:0] entry1_address;
    logic [3:0]      entry_count;
    logic            pop0;
    logic            pop1;
    logic            issue0_valid;
    logic [XLEN-1:0] issue0_instruction;
    logic [XLEN-1:0] issue0_address;
    logic            issue0_ready;
    logic            issue1_valid;
    logic [XLEN-1:0] issue1_instruction;
    logic [XLEN-1:0] issue1_address;
    logic            issue1_ready;
    logic            wb0_valid;
    logic [4:0]      wb0_rd;
    logic            wb1_valid;
    logic [4:0]      wb1_rd;

    modport master (
        input  flush, entry0_instruction, entry0_address,
               entry1_instruction, entry1_address, entry_count,
               issue0_ready, issue1_ready,
               wb0_valid, wb0_rd, wb1_valid, wb1_rd,
        output pop0, pop1,
               issue0_valid, issue0_instruction, issue0_address,
               issue1_valid, issue1_instruction, issue1_address
    );

    modport slave (
        output flush, entry0_instruction, entry0_address,
               entry1_instruction, entry1_address, entry_count,
               issue0_ready, issue1_ready,
               wb0_valid, wb0_rd, wb1_valid, wb1_rd,
        input  pop0, pop1,
               issue0_valid, issue0_instruction, issue0_address,
               issue1_valid, issue1_instruction, issue1_address
    );
endinterface

// File: rtl/dispatch_decode.sv
// dispatch_decode: combinational extraction of register fields and usage flags.
//   instruction : raw instruction word
//   fields      : rd (0 if none), rs1, rs2, source-usage flags, control-flow flag
module dispatch_decode
    import dispatch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instruction,
    output dec_fields_t     fields
);

    logic [6:0] opcode;
    logic       has_rd;
    logic       unused_bits;

    assign opcode      = instruction[6:0];
    // Immediate / funct bits play no part in hazard detection.
    assign unused_bits = ^{instruction[XLEN-1:25], instruction[14:12]};

    always_comb begin
        has_rd          = 1'b1;
        fields.uses_rs1 = 1'b1;
        fields.uses_rs2 = 1'b0;
        fields.is_ctrl  = 1'b0;

        // Unlisted opcodes are conservatively treated as writing rd and reading rs1.
        case (opcode)
            BRANCH: begin
                has_rd          = 1'b0;
                fields.uses_rs2 = 1'b1;
                fields.is_ctrl  = 1'b1;
            end
            STORE: begin
                has_rd          = 1'b0;
                fields.uses_rs2 = 1'b1;
            end
            SYSTEM: begin
                has_rd          = 1'b0;
                fields.is_ctrl  = 1'b1;
            end
            OP:            fields.uses_rs2 = 1'b1;
            JAL: begin
                fields.uses_rs1 = 1'b0;
                fields.is_ctrl  = 1'b1;
            end
            JALR:          fields.is_ctrl  = 1'b1;
            LUI, AUIPC:    fields.uses_rs1 = 1'b0;
            OP_IMM, LOAD:  has_rd          = 1'b1;
            default:       has_rd          = 1'b1;
        endcase

        fields.rd  = has_rd ? instruction[11:7] : 5'd0;
        fields.rs1 = instruction[19:15];
        fields.rs2 = instruction[24:20];
    end

endmodule

// File: rtl/instruction_dispatcher.sv
// instruction_dispatcher: dual-issue in-order dispatch stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instruction_dispatcher_if.master
//                - buffer side: entry0/1 instruction+address, entry_count, pop0/pop1
//                - issue side : issue0/1 valid/instruction/address, issue0/1 ready
//                - writeback  : wb0/1 valid + rd (clear scoreboard busy bits)
//                - flush      : drops both issue slots and their busy bits
// Hazards are checked against a registered busy scoreboard (no writeback bypass).
module instruction_dispatcher
    import dispatch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int PAIR_CTRL = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instruction_dispatcher_if.master bus
);

    dec_fields_t d0;
    dec_fields_t d1;

    dispatch_decode #(.XLEN(XLEN)) u_dec0 (
        .instruction (bus.entry0_instruction),
        .fields      (d0)
    );

    dispatch_decode #(.XLEN(XLEN)) u_dec1 (
        .instruction (bus.entry1_instruction),
        .fields      (d1)
    );

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                issue0_valid_q, issue0_valid_d;
    logic                issue1_valid_q, issue1_valid_d;
    logic [XLEN-1:0]     issue0_instr_q, issue0_instr_d;
    logic [XLEN-1:0]     issue1_instr_q, issue1_instr_d;
    logic [XLEN-1:0]     issue0_addr_q, issue0_addr_d;
    logic [XLEN-1:0]     issue1_addr_q, issue1_addr_d;
    // rd of each held slot, kept so a flush can release its busy bit.
    logic [4:0]          issue0_rd_q, issue0_rd_d;
    logic [4:0]          issue1_rd_q, issue1_rd_d;

    logic slots_free;
    logic hazard0, hazard1, pair_conflict;
    logic pop0_c, pop1_c;

    always_comb begin
        slots_free = (!issue0_valid_q || bus.issue0_ready) &&
                     (!issue1_valid_q || bus.issue1_ready);

        // Bit 0 of the scoreboard is never set, so x0 never creates a hazard.
        hazard0 = (d0.uses_rs1 && busy_q[d0.rs1]) ||
                  (d0.uses_rs2 && busy_q[d0.rs2]) ||
                  busy_q[d0.rd];
        hazard1 = (d1.uses_rs1 && busy_q[d1.rs1]) ||
                  (d1.uses_rs2 && busy_q[d1.rs2]) ||
                  busy_q[d1.rd];

        pair_conflict = 1'b0;
        if (d0.rd != 5'd0) begin
            if ((d1.uses_rs1 && d1.rs1 == d0.rd) ||
                (d1.uses_rs2 && d1.rs2 == d0.rd) ||
                (d1.rd == d0.rd))
                pair_conflict = 1'b1;
        end
        if (d0.is_ctrl && PAIR_CTRL == 0)
            pair_conflict = 1'b1;

        pop0_c = rst_n && !bus.flush && slots_free &&
                 (bus.entry_count != 4'd0) && !hazard0;
        pop1_c = pop0_c && (bus.entry_count >= 4'd2) && !hazard1 && !pair_conflict;
    end

    assign bus.pop0 = pop0_c;
    assign bus.pop1 = pop1_c;

    always_comb begin
        issue0_valid_d = issue0_valid_q;
        issue1_valid_d = issue1_valid_q;
        issue0_instr_d = issue0_instr_q;
        issue1_instr_d = issue1_instr_q;
        issue0_addr_d  = issue0_addr_q;
        issue1_addr_d  = issue1_addr_q;
        issue0_rd_d    = issue0_rd_q;
        issue1_rd_d    = issue1_rd_q;

        if (bus.flush) begin
            issue0_valid_d = 1'b0;
            issue1_valid_d = 1'b0;
        end else if (pop0_c) begin
            issue0_valid_d = 1'b1;
            issue0_instr_d = bus.entry0_instruction;
            issue0_addr_d  = bus.entry0_address;
            issue0_rd_d    = d0.rd;
            issue1_valid_d = pop1_c;
            issue1_instr_d = bus.entry1_instruction;
            issue1_addr_d  = bus.entry1_address;
            issue1_rd_d    = d1.rd;
        end else begin
            if (bus.issue0_ready) issue0_valid_d = 1'b0;
            if (bus.issue1_ready) issue1_valid_d = 1'b0;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (bus.wb0_valid) busy_d[bus.wb0_rd] = 1'b0;
        if (bus.wb1_valid) busy_d[bus.wb1_rd] = 1'b0;
        if (bus.flush) begin
            if (issue0_valid_q) busy_d[issue0_rd_q] = 1'b0;
            if (issue1_valid_q) busy_d[issue1_rd_q] = 1'b0;
        end else begin
            // Applied after the writeback clears so a same-cycle set wins.
            if (pop0_c) busy_d[d0.rd] = 1'b1;
            if (pop1_c) busy_d[d1.rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            issue0_valid_q <= 1'b0;
            issue1_valid_q <= 1'b0;
            issue0_instr_q <= '0;
            issue1_instr_q <= '0;
            issue0_addr_q  <= '0;
            issue1_addr_q  <= '0;
            issue0_rd_q    <= '0;
            issue1_rd_q    <= '0;
        end else begin
            busy_q         <= busy_d;
            issue0_valid_q <= issue0_valid_d;
            issue1_valid_q <= issue1_valid_d;
            issue0_instr_q <= issue0_instr_d;
            issue1_instr_q <= issue1_instr_d;
            issue0_addr_q  <= issue0_addr_d;
            issue1_addr_q  <= issue1_addr_d;
            issue0_rd_q    <= issue0_rd_d;
            issue1_rd_q    <= issue1_rd_d;
        end
    end

    assign bus.issue0_valid       = issue0_valid_q;
    assign bus.issue1_valid       = issue1_valid_q;
    assign bus.issue0_instruction = issue0_instr_q;
    assign bus.issue1_instruction = issue1_instr_q;
    assign bus.issue0_address     = issue0_addr_q;
    assign bus.issue1_address     = issue1_addr_q;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Testbench for instruction_dispatcher: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_instruction_dispatcher;

    logic clk;
    logic rst_n;

    instruction_dispatcher_if #(.XLEN(32)) bus ();

    instruction_dispatcher #(.XLEN(32), .NUM_REGS(32), .PAIR_CTRL(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } ent_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    ent_t        q[$];
    logic [31:0] next_pc;
    bit   [31:0] busy;
    bit          m_v[2];
    logic [31:0] m_instr[2];
    logic [31:0] m_addr[2];

    // Observations recorded by the last cycle
    logic        obs_p0, obs_p1, obs_v0, obs_v1;
    logic [31:0] obs_a0, obs_a1, obs_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---- instruction semantics ----
    function automatic bit writes_rd(logic [31:0] i);
        return !(i[6:0] == 7'b1100011 || i[6:0] == 7'b0100011 || i[6:0] == 7'b1110011);
    endfunction

    function automatic bit [31:0] dst_mask(logic [31:0] i);
        bit [31:0] m = '0;
        if (writes_rd(i)) m[i[11:7]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic bit [31:0] src_mask(logic [31:0] i);
        bit [31:0] m = '0;
        logic [6:0] op = i[6:0];
        if (!(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111)) m[i[19:15]] = 1'b1;
        if (op == 7'b0110011 || op == 7'b1100011 || op == 7'b0100011) m[i[24:20]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic bit ends_pair(logic [31:0] i);
        logic [6:0] op = i[6:0];
        return op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111 || op == 7'b1110011;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        case ($urandom_range(0, 12))
            0, 1, 2: op = 7'b0010011;
            3, 4:    op = 7'b0110011;
            5:       op = 7'b0000011;
            6:       op = 7'b0100011;
            7:       op = 7'b1100011;
            8:       op = 7'b1101111;
            9:       op = 7'b1100111;
            10:      op = 7'b0110111;
            11:      op = 7'b0010111;
            default: op = 7'b1110011;
        endcase
        return {7'($urandom_range(0, 127)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 3'b000, 5'($urandom_range(0, 7)), op};
    endfunction

    task automatic push(input logic [31:0] instr);
        q.push_back({instr, next_pc});
        next_pc = next_pc + 32'd4;
    endtask

    task automatic model_reset();
        busy = '0;
        m_v[0] = 1'b0;
        m_v[1] = 1'b0;
    endtask

    task automatic drive_idle();
        bus.flush = 1'b0;
        bus.entry_count = 4'd0;
        bus.entry0_instruction = 32'h13;
        bus.entry0_address = 32'h0;
        bus.entry1_instruction = 32'h13;
        bus.entry1_address = 32'h0;
        bus.issue0_ready = 1'b0;
        bus.issue1_ready = 1'b0;
        bus.wb0_valid = 1'b0;
        bus.wb0_rd = 5'd0;
        bus.wb1_valid = 1'b0;
        bus.wb1_rd = 5'd0;
    endtask

    // One clock cycle: drive at negedge, check just after, advance the model.
    task automatic cycle(input bit fl, input bit r0, input bit r1,
                         input bit w0v, input logic [4:0] w0r,
                         input bit w1v, input logic [4:0] w1r,
                         input logic [3:0] cnt);
        ent_t      e0, e1;
        bit        free, exp_p0, exp_p1;
        bit [31:0] nb;
        @(negedge clk);
        e0 = (q.size() > 0) ? q[0] : {32'h13, 32'h0};
        e1 = (q.size() > 1) ? q[1] : {32'h13, 32'h0};
        bus.flush = fl;
        bus.entry_count = cnt;
        bus.entry0_instruction = e0.instr;
        bus.entry0_address = e0.addr;
        bus.entry1_instruction = e1.instr;
        bus.entry1_address = e1.addr;
        bus.issue0_ready = r0;
        bus.issue1_ready = r1;
        bus.wb0_valid = w0v;
        bus.wb0_rd = w0r;
        bus.wb1_valid = w1v;
        bus.wb1_rd = w1r;
        #1;
        obs_p0 = bus.pop0;
        obs_p1 = bus.pop1;
        obs_v0 = bus.issue0_valid;
        obs_v1 = bus.issue1_valid;
        obs_a0 = bus.issue0_address;
        obs_a1 = bus.issue1_address;
        obs_busy = dut.busy_q;

        free   = (!m_v[0] || r0) && (!m_v[1] || r1);
        exp_p0 = !fl && free && cnt >= 1 &&
                 ((src_mask(e0.instr) | dst_mask(e0.instr)) & busy) == '0;
        exp_p1 = exp_p0 && cnt >= 2 &&
                 ((src_mask(e1.instr) | dst_mask(e1.instr)) & busy) == '0 &&
                 ((src_mask(e1.instr) | dst_mask(e1.instr)) & dst_mask(e0.instr)) == '0 &&
                 !ends_pair(e0.instr);

        chk("pop0", obs_p0, exp_p0);
        chk("pop1", obs_p1, exp_p1);
        chk("issue0_valid", obs_v0, m_v[0]);
        chk("issue1_valid", obs_v1, m_v[1]);
        if (m_v[0]) begin
            chk("issue0_instr", bus.issue0_instruction, m_instr[0]);
            chk("issue0_addr", obs_a0, m_addr[0]);
        end
        if (m_v[1]) begin
            chk("issue1_instr", bus.issue1_instruction, m_instr[1]);
            chk("issue1_addr", obs_a1, m_addr[1]);
        end
        chk("scoreboard", obs_busy, busy);

        nb = busy;
        if (w0v) nb[w0r] = 1'b0;
        if (w1v) nb[w1r] = 1'b0;
        if (fl) begin
            if (m_v[0]) nb = nb & ~dst_mask(m_instr[0]);
            if (m_v[1]) nb = nb & ~dst_mask(m_instr[1]);
            m_v[0] = 1'b0;
            m_v[1] = 1'b0;
        end else if (exp_p0) begin
            nb = nb | dst_mask(e0.instr);
            if (exp_p1) nb = nb | dst_mask(e1.instr);
            m_v[0] = 1'b1;
            m_instr[0] = e0.instr;
            m_addr[0] = e0.addr;
            m_v[1] = exp_p1;
            m_instr[1] = e1.instr;
            m_addr[1] = e1.addr;
        end else begin
            if (r0) m_v[0] = 1'b0;
            if (r1) m_v[1] = 1'b0;
        end
        busy = nb;
        if (exp_p0) void'(q.pop_front());
        if (exp_p1) void'(q.pop_front());
    endtask

    task automatic async_reset();
        @(negedge clk);
        drive_idle();
        bus.entry_count = 4'd1;
        bus.entry0_instruction = 32'h00100093;
        bus.issue0_ready = 1'b1;
        bus.issue1_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_issue0_valid", bus.issue0_valid, 1'b0);
        chk("arst_issue1_valid", bus.issue1_valid, 1'b0);
        chk("arst_scoreboard", dut.busy_q, 32'h0);
        chk("arst_pop0", bus.pop0, 1'b0);
        drive_idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          c;
        int          busy_list[$];
        bit          fl, r0, r1, w0v, w1v;
        logic [4:0]  w0r, w1r;

        next_pc = 32'h100;
        model_reset();
        drive_idle();
        rst_n = 1'b0;
        #2;
        chk("rst_issue0_valid", bus.issue0_valid, 1'b0);
        chk("rst_issue1_valid", bus.issue1_valid, 1'b0);
        chk("rst_scoreboard", dut.busy_q, 32'h0);
        chk("rst_pop0", bus.pop0, 1'b0);
        chk("rst_issue0_addr", bus.issue0_address, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Independent pair
        push(32'h00100093);
        push(32'h00200113);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd2);
        chk("t1_pop0", obs_p0, 1'b1);
        chk("t1_pop1", obs_p1, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 0, 4'd0);
        chk("t1_v0", obs_v0, 1'b1);
        chk("t1_v1", obs_v1, 1'b1);
        chk("t1_pc0", obs_a0, 32'h100);
        chk("t1_pc1", obs_a1, 32'h104);
        chk("t1_busy", obs_busy, 32'h6);
        cycle(0, 1, 1, 1, 5'd1, 1, 5'd2, 4'd0);

        // Intra-pair RAW, then scoreboard RAW released one cycle after writeback
        push(32'h00100093);
        push(32'h002081B3);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd2);
        chk("t2_pop0", obs_p0, 1'b1);
        chk("t2_pop1", obs_p1, 1'b0);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd1);
        chk("t2_stall", obs_p0, 1'b0);
        cycle(0, 1, 1, 1, 5'd1, 0, 0, 4'd1);
        chk("t2_wb_cycle", obs_p0, 1'b0);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd1);
        chk("t2_after_wb", obs_p0, 1'b1);

        // Control-flow instruction issues alone
        cycle(0, 1, 1, 1, 5'd3, 0, 0, 4'd0);
        push(32'h00000463);
        push(32'h00100093);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd2);
        chk("t3_pop0", obs_p0, 1'b1);
        chk("t3_pop1", obs_p1, 1'b0);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd1);
        chk("t3_next_pop0", obs_p0, 1'b1);

        // Backpressure on slot 1
        push(32'h00200113);
        push(32'h00400213);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd2);
        push(32'h00600313);
        push(32'h00700393);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd2);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 0, 0, 0, 0, 4'd2);
            chk("t4_hold_pop0", obs_p0, 1'b0);
        end
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd2);
        chk("t4_resume_pop0", obs_p0, 1'b1);

        // Flush while slot 0 holds addi x5
        push(32'h00500293);
        cycle(0, 1, 1, 0, 0, 0, 0, 4'd1);
        cycle(1, 0, 0, 0, 0, 0, 0, 4'd0);
        chk("t5_pop0", obs_p0, 1'b0);
        cycle(0, 0, 0, 0, 0, 0, 0, 4'd0);
        chk("t5_v0", obs_v0, 1'b0);
        chk("t5_busy_x5", obs_busy[5], 1'b0);
        chk("t5_busy_x6", obs_busy[6], 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            while (q.size() < 6) push(rand_instr());
            fl = ($urandom_range(0, 29) == 0);
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            c = $urandom_range(1, 4);
            if (c > q.size()) c = q.size();
            if ($urandom_range(0, 7) == 0) c = 0;
            busy_list.delete();
            for (int r = 1; r < 32; r++) if (busy[r]) busy_list.push_back(r);
            w0v = 1'b0;
            w1v = 1'b0;
            w0r = 5'($urandom_range(0, 31));
            w1r = 5'($urandom_range(0, 31));
            if (busy_list.size() > 0) begin
                w0v = ($urandom_range(0, 2) != 0);
                w1v = ($urandom_range(0, 3) == 0);
                w0r = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
                w1r = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            end
            cycle(fl, r0, r1, w0v, w0r, w1v, w1r, 4'(c));
            if (i == 1500) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
